uart_mm_master: RTL and testbench

- Bus initiator that drives the memory-mapped port of mm_uart. Hardware clients can then send and receive bytes through simple valid/ready byte streams, with no processor involved.
- Polls TX_READY/RX_READY, writes TX bytes from an internal FIFO, reads RX bytes into an output holding register.
- Sits between on-chip byte producers/consumers (boot loader, debug monitor) and mm_uart.

---
 rtl/uart_mm_master_pkg.sv | 23 ++
 rtl/uart_mm_master_if.sv | 22 ++
 rtl/uart_mm_tx_fifo.sv | 44 ++++
 rtl/uart_mm_master.sv | 140 ++++++++++++++
 tb/tb_uart_mm_master.sv | 331 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/uart_mm_master_pkg.sv
// Shared types and default mm_uart register map for the UART memory-mapped master.
package uart_mm_master_pkg;

    localparam int BYTE_WIDTH = 8;

    localparam logic [31:0] DEF_RX_ADDR       = 32'h9000_0010;
    localparam logic [31:0] DEF_RX_READY_ADDR = 32'h9000_0014;
    localparam logic [31:0] DEF_TX_ADDR       = 32'h9000_0020;
    localparam logic [31:0] DEF_TX_READY_ADDR = 32'h9000_0024;

    typedef enum logic [3:0] {
        IDLE      = 4'd0,
        POLL_TX   = 4'd1,
        CHK_TX    = 4'd2,
        WR_TX     = 4'd3,
        TX_SETTLE = 4'd4,
        POLL_RX   = 4'd5,
        CHK_RX    = 4'd6,
        RD_RX     = 4'd7,
        CAP_RX    = 4'd8
    } state_t;

endpackage

// File: rtl/uart_mm_master_if.sv
// Memory-mapped bus between the UART master (initiator) and mm_uart (target).
interface uart_mm_master_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32
);
    logic                    readEnable;
    logic                    writeEnable;
    logic [DATA_WIDTH/8-1:0] writeByteEnable;
    logic [ADDR_WIDTH-1:0]   address;
    logic [DATA_WIDTH-1:0]   writeData;
    logic [DATA_WIDTH-1:0]   readData;

    modport master (
        output readEnable, writeEnable, writeByteEnable, address, writeData,
        input  readData
    );

    modport slave (
        input  readEnable, writeEnable, writeByteEnable, address, writeData,
        output readData
    );
endinterface

// File: rtl/uart_mm_tx_fifo.sv
// TX byte FIFO: registered storage, head visible combinationally; a push while full
// is accepted only together with a pop in the same cycle.
module uart_mm_tx_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             i_push,
    input  logic             i_pop,
    input  logic [WIDTH-1:0] i_data,
    output logic [WIDTH-1:0] o_data,
    output logic             o_full,
    output logic             o_empty
);
    localparam int AW = $clog2(DEPTH);

    logic [AW:0]      r_wptr;
    logic [AW:0]      r_rptr;
    logic [WIDTH-1:0] r_mem [DEPTH];
    logic             w_push;
    logic             w_pop;

    assign w_pop   = i_pop && !o_empty;
    assign w_push  = i_push && (!o_full || w_pop);
    assign o_empty = (r_wptr == r_rptr);
    assign o_full  = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
    assign o_data  = r_mem[r_rptr[AW-1:0]];

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else begin
            if (w_push) r_wptr <= r_wptr + 1'b1;
            if (w_pop)  r_rptr <= r_rptr + 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (w_push) r_mem[r_wptr[AW-1:0]] <= i_data;
    end

endmodule

// File: rtl/uart_mm_master.sv
// Polls mm_uart status and moves bytes between valid/ready streams and the mm port,
// alternating TX and RX service; RX backpressure simply stops RX polling.
module uart_mm_master
    import uart_mm_master_pkg::*;
#(
    parameter int                    DATA_WIDTH    = 32,
    parameter int                    ADDR_WIDTH    = 32,
    parameter logic [ADDR_WIDTH-1:0] RX_ADDR       = DEF_RX_ADDR,
    parameter logic [ADDR_WIDTH-1:0] TX_ADDR       = DEF_TX_ADDR,
    parameter logic [ADDR_WIDTH-1:0] RX_READY_ADDR = DEF_RX_READY_ADDR,
    parameter logic [ADDR_WIDTH-1:0] TX_READY_ADDR = DEF_TX_READY_ADDR,
    parameter int                    TX_FIFO_DEPTH = 4
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [BYTE_WIDTH-1:0] tx_byte,
    input  logic                  tx_valid,
    output logic                  tx_ready,
    output logic [BYTE_WIDTH-1:0] rx_byte,
    output logic                  rx_valid,
    input  logic                  rx_ready,
    uart_mm_master_if.master      mm
);
    localparam int BE_W = DATA_WIDTH / 8;
    localparam logic [DATA_WIDTH-1:0] STATUS_READY = {{(DATA_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [BE_W-1:0]       BE_BYTE0     = {{(BE_W-1){1'b0}}, 1'b1};

    state_t                  r_state;
    logic                    r_prio_rx;
    logic                    r_re;
    logic                    r_we;
    logic [BE_W-1:0]         r_be;
    logic [ADDR_WIDTH-1:0]   r_addr;
    logic [DATA_WIDTH-1:0]   r_wd;
    logic                    r_rx_vld;
    logic [BYTE_WIDTH-1:0]   r_rx_byte;

    logic                    w_full;
    logic                    w_empty;
    logic [BYTE_WIDTH-1:0]   w_head;
    logic                    w_tx_elig;
    logic                    w_rx_elig;
    logic                    w_status_ok;

    uart_mm_tx_fifo #(
        .DEPTH (TX_FIFO_DEPTH),
        .WIDTH (BYTE_WIDTH)
    ) u_tx_fifo (
        .clock   (clock),
        .reset   (reset),
        .i_push  (tx_valid && tx_ready),
        .i_pop   (r_state == WR_TX),
        .i_data  (tx_byte),
        .o_data  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    assign tx_ready    = !w_full && !reset;
    assign w_tx_elig   = !w_empty;
    assign w_rx_elig   = !r_rx_vld;
    assign w_status_ok = (mm.readData == STATUS_READY);

    assign mm.readEnable      = r_re;
    assign mm.writeEnable     = r_we;
    assign mm.writeByteEnable = r_be;
    assign mm.address         = r_addr;
    assign mm.writeData       = r_wd;
    assign rx_valid           = r_rx_vld;
    assign rx_byte            = r_rx_byte;

    // Bus outputs are loaded on entry to each state so they are glitch-free registers.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state   <= IDLE;
            r_prio_rx <= 1'b0;
            r_re      <= 1'b0;
            r_we      <= 1'b0;
            r_be      <= '0;
            r_addr    <= '0;
            r_wd      <= '0;
            r_rx_vld  <= 1'b0;
            r_rx_byte <= '0;
        end else begin
            r_re   <= 1'b0;
            r_we   <= 1'b0;
            r_be   <= '0;
            r_addr <= '0;
            r_wd   <= '0;
            if (r_rx_vld && rx_ready) r_rx_vld <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_tx_elig && (!w_rx_elig || !r_prio_rx)) begin
                        r_state   <= POLL_TX;
                        r_prio_rx <= 1'b1;
                        r_re      <= 1'b1;
                        r_addr    <= TX_READY_ADDR;
                    end else if (w_rx_elig) begin
                        r_state   <= POLL_RX;
                        r_prio_rx <= 1'b0;
                        r_re      <= 1'b1;
                        r_addr    <= RX_READY_ADDR;
                    end
                end
                POLL_TX: r_state <= CHK_TX;
                CHK_TX: begin
                    if (w_status_ok) begin
                        r_state <= WR_TX;
                        r_we    <= 1'b1;
                        r_be    <= BE_BYTE0;
                        r_addr  <= TX_ADDR;
                        r_wd    <= {{(DATA_WIDTH-BYTE_WIDTH){1'b0}}, w_head};
                    end else begin
                        r_state <= IDLE;
                    end
                end
                WR_TX:     r_state <= TX_SETTLE;
                TX_SETTLE: r_state <= IDLE;
                POLL_RX:   r_state <= CHK_RX;
                CHK_RX: begin
                    if (w_status_ok) begin
                        r_state <= RD_RX;
                        r_re    <= 1'b1;
                        r_addr  <= RX_ADDR;
                    end else begin
                        r_state <= IDLE;
                    end
                end
                RD_RX: r_state <= CAP_RX;
                CAP_RX: begin
                    r_rx_byte <= mm.readData[BYTE_WIDTH-1:0];
                    r_rx_vld  <= 1'b1;
                    r_state   <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_mm_master.sv
// Directed bench for uart_mm_master with a behavioural mm_uart target model.
module tb_uart_mm_master;
    import uart_mm_master_pkg::*;

    localparam byte EV_NONE = 8'd0;
    localparam byte EV_T    = 8'd1;
    localparam byte EV_R    = 8'd2;
    localparam byte EV_D    = 8'd3;
    localparam byte EV_W    = 8'd4;
    localparam byte EV_X    = 8'd5;

    typedef struct {
        logic [7:0] din;
        logic       exp;
    } vec_t;

    logic       clock = 1'b0;
    logic       reset;
    logic [7:0] tx_byte;
    logic       tx_valid;
    logic       tx_ready;
    logic [7:0] rx_byte;
    logic       rx_valid;
    logic       rx_ready;

    int n_checks = 0;
    int n_pass   = 0;

    uart_mm_master_if #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) m ();

    uart_mm_master dut (
        .clock    (clock),
        .reset    (reset),
        .tx_byte  (tx_byte),
        .tx_valid (tx_valid),
        .tx_ready (tx_ready),
        .rx_byte  (rx_byte),
        .rx_valid (rx_valid),
        .rx_ready (rx_ready),
        .mm       (m.master)
    );

    always #5 clock = ~clock;

    // Target model configuration owned by the stimulus process
    logic       tx_rdy_cfg = 1'b0;
    logic       rx_sticky  = 1'b0;
    logic       loopback   = 1'b0;
    logic [7:0] rx_data_cfg = 8'h00;
    int         rx_post = 0;

    // Target model state owned by the model process
    int          rx_seen = 0;
    logic        lb_pend = 1'b0;
    logic [7:0]  lb_data = 8'h00;
    int          lb_cnt  = 0;
    logic [31:0] rd = 32'h0;
    logic        rx_rdy_now;
    logic        tx_rdy_now;

    assign rx_rdy_now = rx_sticky || (rx_post != rx_seen) || lb_pend;
    assign tx_rdy_now = tx_rdy_cfg && (lb_cnt == 0);
    assign m.readData = rd;

    always @(posedge clock) begin
        if (lb_cnt > 0) begin
            lb_cnt <= lb_cnt - 1;
            if (lb_cnt == 1) lb_pend <= 1'b1;
        end
        if (m.writeEnable && m.address == DEF_TX_ADDR && m.writeByteEnable == 4'h1 && loopback) begin
            lb_cnt  <= 8;
            lb_data <= m.writeData[7:0];
        end
        if (m.readEnable) begin
            case (m.address)
                DEF_TX_READY_ADDR: rd <= {31'b0, tx_rdy_now};
                DEF_RX_READY_ADDR: rd <= {31'b0, rx_rdy_now};
                DEF_RX_ADDR: begin
                    rd      <= {24'b0, (lb_pend ? lb_data : rx_data_cfg)};
                    rx_seen <= rx_post;
                    lb_pend <= 1'b0;
                end
                default: rd <= 32'hDEAD_BEEF;
            endcase
        end else begin
            rd <= 32'hDEAD_BEEF;
        end
    end

    // Bus activity log, one entry per cycle
    byte         ev_q[$];
    logic [31:0] wr_q[$];
    logic [3:0]  be_q[$];

    always @(negedge clock) begin
        if (!reset) begin
            if (m.writeEnable) begin
                ev_q.push_back(EV_W);
                wr_q.push_back(m.writeData);
                be_q.push_back(m.writeByteEnable);
            end else if (m.readEnable) begin
                case (m.address)
                    DEF_TX_READY_ADDR: ev_q.push_back(EV_T);
                    DEF_RX_READY_ADDR: ev_q.push_back(EV_R);
                    DEF_RX_ADDR:       ev_q.push_back(EV_D);
                    default:           ev_q.push_back(EV_X);
                endcase
            end else begin
                ev_q.push_back(EV_NONE);
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    task automatic clear_log();
        @(posedge clock);
        #1;
        ev_q.delete();
        wr_q.delete();
        be_q.delete();
    endtask

    function automatic int cnt(input byte code);
        int n = 0;
        foreach (ev_q[i]) if (ev_q[i] == code) n++;
        return n;
    endfunction

    function automatic logic wr_framed(input int i);
        if (i < 2 || i + 1 >= ev_q.size()) return 1'b0;
        return ev_q[i-2] == EV_T && ev_q[i-1] == EV_NONE && ev_q[i+1] == EV_NONE;
    endfunction

    task automatic push(input logic [7:0] b);
        tx_byte  = b;
        tx_valid = 1'b1;
        @(negedge clock);
        tx_valid = 1'b0;
    endtask

    task automatic wait_rx_valid(input int budget);
        int n = 0;
        while (!rx_valid && n < budget) begin
            @(negedge clock);
            n++;
        end
        chk("rx_valid_wait", {31'b0, rx_valid}, 32'd1);
    endtask

    vec_t burst_tbl[4];
    vec_t rx_tbl[4];

    initial begin
        burst_tbl[0] = '{8'h11, 1'b1};
        burst_tbl[1] = '{8'h22, 1'b1};
        burst_tbl[2] = '{8'h33, 1'b1};
        burst_tbl[3] = '{8'h44, 1'b0};
        rx_tbl[0]    = '{8'h5A, 1'b1};
        rx_tbl[1]    = '{8'h00, 1'b1};
        rx_tbl[2]    = '{8'hFF, 1'b1};
        rx_tbl[3]    = '{8'hA5, 1'b1};

        reset    = 1'b1;
        tx_byte  = 8'h00;
        tx_valid = 1'b0;
        rx_ready = 1'b0;

        // Reset values
        repeat (3) @(negedge clock);
        chk("rst_readEnable",  {31'b0, m.readEnable},  32'd0);
        chk("rst_writeEnable", {31'b0, m.writeEnable}, 32'd0);
        chk("rst_byteEnable",  {28'b0, m.writeByteEnable}, 32'd0);
        chk("rst_address",     m.address,   32'd0);
        chk("rst_writeData",   m.writeData, 32'd0);
        chk("rst_rx_valid",    {31'b0, rx_valid}, 32'd0);
        chk("rst_rx_byte",     {24'b0, rx_byte},  32'd0);
        chk("rst_tx_ready",    {31'b0, tx_ready}, 32'd0);
        reset = 1'b0;
        @(negedge clock);
        chk("post_rst_tx_ready", {31'b0, tx_ready}, 32'd1);
        clear_log();
        repeat (15) @(negedge clock);
        chk("idle_rx_polls_seen", {31'b0, (cnt(EV_R) > 0)}, 32'd1);
        chk("idle_no_tx_poll", cnt(EV_T), 32'd0);
        chk("idle_no_access",  cnt(EV_W) + cnt(EV_D), 32'd0);

        // Loopback single byte
        loopback   = 1'b1;
        tx_rdy_cfg = 1'b1;
        clear_log();
        @(negedge clock);
        push(8'hAB);
        wait_rx_valid(100);
        chk("lb_write_count", wr_q.size(), 32'd1);
        if (wr_q.size() > 0) begin
            chk("lb_write_data", wr_q[0], 32'h0000_00AB);
            chk("lb_write_be",   {28'b0, be_q[0]}, 32'h1);
        end
        begin
            int iw = -1;
            foreach (ev_q[i]) if (ev_q[i] == EV_W && iw < 0) iw = i;
            chk("lb_write_framed", {31'b0, wr_framed(iw)}, 32'd1);
        end
        chk("lb_rx_byte", {24'b0, rx_byte}, 32'h0000_00AB);
        rx_ready = 1'b1;
        @(negedge clock);
        chk("lb_rx_consumed", {31'b0, rx_valid}, 32'd0);
        rx_ready = 1'b0;
        loopback = 1'b0;

        // Burst until full, with TX_READY held low
        tx_rdy_cfg = 1'b0;
        repeat (3) @(negedge clock);
        for (int i = 0; i < 4; i++) begin
            push(burst_tbl[i].din);
            chk($sformatf("burst_tx_ready_%0d", i), {31'b0, tx_ready}, {31'b0, burst_tbl[i].exp});
        end
        tx_byte  = 8'h55;
        tx_valid = 1'b1;
        repeat (3) @(negedge clock);
        chk("full_tx_ready", {31'b0, tx_ready}, 32'd0);
        tx_valid = 1'b0;
        clear_log();
        tx_rdy_cfg = 1'b1;
        repeat (60) @(negedge clock);
        chk("burst_write_count", wr_q.size(), 32'd4);
        for (int i = 0; i < 4 && i < wr_q.size(); i++)
            chk($sformatf("burst_write_%0d", i), wr_q[i], {24'b0, burst_tbl[i].din});
        begin
            int k = 0;
            foreach (ev_q[i]) if (ev_q[i] == EV_W) begin
                chk($sformatf("burst_framed_%0d", k), {31'b0, wr_framed(i)}, 32'd1);
                k++;
            end
        end

        // RX backpressure: exactly one data read, then no polls while held
        clear_log();
        rx_data_cfg = 8'h5A;
        rx_post++;
        wait_rx_valid(40);
        repeat (20) @(negedge clock);
        chk("bp_rx_valid_held", {31'b0, rx_valid}, 32'd1);
        chk("bp_rx_byte", {24'b0, rx_byte}, 32'h5A);
        chk("bp_one_read", cnt(EV_D), 32'd1);
        begin
            int id = -1;
            int nr = 0;
            foreach (ev_q[i]) begin
                if (id >= 0 && ev_q[i] == EV_R) nr++;
                if (ev_q[i] == EV_D && id < 0) id = i;
            end
            chk("bp_no_polls_while_held", nr, 32'd0);
        end
        rx_ready = 1'b1;
        @(negedge clock);
        rx_ready = 1'b0;
        chk("bp_released", {31'b0, rx_valid}, 32'd0);
        clear_log();
        repeat (10) @(negedge clock);
        chk("bp_polls_resume", {31'b0, (cnt(EV_R) > 0)}, 32'd1);

        // RX table
        for (int i = 1; i < 4; i++) begin
            rx_data_cfg = rx_tbl[i].din;
            rx_post++;
            wait_rx_valid(40);
            chk($sformatf("rx_byte_%0d", i), {24'b0, rx_byte}, {24'b0, rx_tbl[i].din});
            rx_ready = 1'b1;
            @(negedge clock);
            rx_ready = 1'b0;
            chk($sformatf("rx_consumed_%0d", i), {31'b0, rx_valid}, {31'b0, !rx_tbl[i].exp});
        end

        // Simultaneous service alternation
        tx_rdy_cfg = 1'b0;
        for (int i = 0; i < 4; i++) push(8'hC0 + 8'(i));
        clear_log();
        rx_ready    = 1'b1;
        rx_sticky   = 1'b1;
        rx_data_cfg = 8'h3C;
        tx_rdy_cfg  = 1'b1;
        repeat (80) @(negedge clock);
        rx_sticky = 1'b0;
        begin
            byte svc[$];
            int  nw = 0;
            foreach (ev_q[i]) if (ev_q[i] == EV_W || ev_q[i] == EV_D) svc.push_back(ev_q[i]);
            chk("alt_service_count", {31'b0, (svc.size() >= 8)}, 32'd1);
            for (int k = 0; k < 8 && k < svc.size(); k++) begin
                if (svc[k] == EV_W) nw++;
                if (k > 0) chk($sformatf("alt_%0d", k), {31'b0, (svc[k] != svc[k-1])}, 32'd1);
            end
            chk("alt_tx_share", nw, 32'd4);
        end
        chk("alt_write_count", wr_q.size(), 32'd4);
        repeat (10) @(negedge clock);

        // Reset during WR_TX
        tx_rdy_cfg = 1'b0;
        for (int i = 0; i < 3; i++) push(8'h70 + 8'(i));
        tx_rdy_cfg = 1'b1;
        begin
            int n = 0;
            while (!m.writeEnable && n < 40) begin
                @(negedge clock);
                n++;
            end
            chk("mid_wr_reached", {31'b0, m.writeEnable}, 32'd1);
        end
        reset = 1'b1;
        #1;
        chk("mid_wr_we_drop",   {31'b0, m.writeEnable}, 32'd0);
        chk("mid_wr_addr_zero", m.address, 32'd0);
        repeat (2) @(negedge clock);
        reset = 1'b0;
        clear_log();
        repeat (30) @(negedge clock);
        chk("mid_wr_no_writes", wr_q.size(), 32'd0);
        chk("mid_wr_tx_ready",  {31'b0, tx_ready}, 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
